sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Clocked front-end for the 8K x 8 asynchronous SRAM (13-bit address, 8-bit bidirectional data, write_enable, read_enable).
//  Shares the single SRAM port between two requesters using round-robin arbitration.
//  Sequences each access as setup -> strobe -> recover, and owns the tristate data bus.
//  Sits between the two client engines and the SRAM instance.
// PARAMETERS
//  ADDR_W       13  SRAM address width
//  DATA_W       8   SRAM data width
//  ACCESS_CYC   2   cycles the enable strobe is held; legal range >= 1
// PORTS
//  clk                in     1         system clock; all logic on rising edge
//  rst                in     1         synchronous, active-high reset
//  req                in     2         per-requester access request; bit i = requester i
//  req_we             in     2         1 = write, 0 = read; per requester
//  req_addr           in     2*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W]
//  req_wdata          in     2*DATA_W  requester i write data at [i*DATA_W +: DATA_W]
//  gnt                out    2         one-cycle pulse; the request is accepted
//  done               out    2         one-cycle pulse; the access is complete (read data valid)
//  rdata              out    DATA_W    captured read data; holds its value until the next read completes
//  busy               out    1         high in every state except IDLE
//  sram_address       out    ADDR_W    to SRAM address
//  sram_data          inout  DATA_W    to SRAM data; driven only during a write in SETUP/ACCESS, otherwise Z
//  sram_write_enable  out    1         SRAM write strobe
//  sram_read_enable   out    1         SRAM read strobe
// BEHAVIOUR
//  Reset:
//   - gnt, done, busy, sram_write_enable, sram_read_enable = 0; rdata = 0; sram_address = 0; sram_data = Z.
//   - State = IDLE; round-robin pointer = 0, so requester 0 wins the first tie.
//  FSM states: IDLE -> SETUP -> ACCESS -> RECOVER -> IDLE.
//   - IDLE: if any req is high, pick a winner, register its we/addr/wdata, pulse gnt[winner], go to SETUP.
//   - SETUP (1 cycle): drive sram_address; drive sram_data on a write; both enables stay 0.
//   - ACCESS (ACCESS_CYC cycles): assert exactly one enable (write -> sram_write_enable, read -> sram_read_enable).
//     - Address and data are held stable.
//     - On a read, rdata captures sram_data on the last ACCESS edge.
//   - RECOVER (1 cycle): both enables 0; sram_data released to Z; address held; pulse done[winner]; go to IDLE.
//  Handshake:
//   - Requester holds req, we, addr and wdata stable until it sees gnt; these inputs are ignored after gnt.
//   - req may stay high for a back-to-back access; it is re-arbitrated in the next IDLE.
//  Latency:
//   - gnt edge to done = ACCESS_CYC+2 cycles.
//   - Per-transaction occupancy = ACCESS_CYC+3 cycles.
//   - Default throughput: one access per 5 cycles.
//  Arbitration:
//   - One request: that requester wins.
//   - Both requesting: the pointer's requester wins; after each grant, the pointer moves to the other requester.
//  Invariants:
//   - sram_write_enable and sram_read_enable are never high together.
//   - sram_data is never driven while sram_read_enable is high.
//  Reset mid-operation: on the rst edge, the transaction is abandoned.
//   - Enables drop; the bus goes to Z.
//   - No done is issued; rdata is reset.
//  Requests arriving during busy are not lost; they wait, unacknowledged, until IDLE.
// CONFIGURATION
//  SRAM_ARB_FIXED_PRI_EN
//   - Defined: fixed priority; requester 0 always wins a tie and the pointer logic is removed.
//   - Undefined (default): round-robin as described above.
// STRUCTURE
//  Package sram_arb_pkg: state enum (IDLE, SETUP, ACCESS, RECOVER), ADDR_W/DATA_W defaults, NUM_REQ=2.
//  Sub-module sram_arb_pick (combinational):
//   - Inputs: req, ptr. Outputs: one-hot winner and valid.
//   - The priority/round-robin choice under SRAM_ARB_FIXED_PRI_EN lives here.
//  Top: FSM, access-cycle counter, address/data/we holding registers, tristate driver, rdata register.
// TESTING
//  Bench: behavioural 8K x 8 SRAM model; assertion that the two enables are never high together.
//  1. Req0 writes 8'hA5 @0, then req1 writes 8'h5A @1.
//     -> gnt[0], then done[0] 4 cycles later; sram_write_enable high exactly 2 cycles per write.
//  2. Req0 reads @0, then @1.
//     -> rdata = 8'hA5, then 8'h5A at the done pulses; sram_data is never driven while sram_read_enable is high.
//  3. req=2'b11 held for 4 transactions.
//     -> grants alternate 0,1,0,1.
//     -> with SRAM_ARB_FIXED_PRI_EN defined: all four grants go to 0.
//  4. Write 8'hFF @13'h1FFF, then read back.
//     -> rdata = 8'hFF; address at top of range, no wrap.
//  5. Assert rst during ACCESS of a write.
//     -> next edge: enables 0, sram_data Z, no done pulse, state IDLE, ptr 0.
//  6. Idle for 10 cycles with req=0.
//     -> sram_data stays Z, busy=0, no gnt.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-requester SRAM port arbiter.
// Holds the access-sequencer state encoding and the requester count.
package sram_arb_pkg;

    localparam int ADDR_W_DEF     = 13;
    localparam int DATA_W_DEF     = 8;
    localparam int ACCESS_CYC_DEF = 2;
    localparam int NUM_REQ        = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RECOVER = 2'd3
    } arb_state_t;

    // One-hot (two requesters) to requester index.
    function automatic logic onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Client-side handshake bundle of the SRAM port arbiter.
// slave = arbiter side, master = requester side.
interface sram_port_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, done, rdata, busy
    );

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, done, rdata, busy
    );
endinterface

// File: rtl/sram_arb_pick.sv
// Combinational winner selection for the two SRAM requesters.
// Macro SRAM_ARB_FIXED_PRI_EN: requester 0 always wins a tie; ptr is ignored.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    always_comb begin
        winner = '0;
        valid  = |req;
`ifdef SRAM_ARB_FIXED_PRI_EN
        if (req[0]) begin
            winner = 2'b01;
        end else if (req[1]) begin
            winner = 2'b10;
        end
`else
        // A lone request is already one-hot; only a tie consults the pointer.
        if (&req) begin
            winner = ptr ? 2'b10 : 2'b01;
        end else begin
            winner = req;
        end
`endif
    end

`ifdef SRAM_ARB_FIXED_PRI_EN
    logic w_ptr_unused;
    assign w_ptr_unused = ptr;
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Clocked front-end sharing one async 8K x 8 SRAM port between two requesters.
// Sequence IDLE -> SETUP -> ACCESS -> RECOVER; optional macro SRAM_ARB_FIXED_PRI_EN.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ACCESS_CYC = ACCESS_CYC_DEF
)(
    input  logic              clk,
    input  logic              rst,
    sram_port_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] sram_address,
    output logic              sram_write_enable,
    output logic              sram_read_enable,
    inout  wire  [DATA_W-1:0] sram_data
);

    localparam int CNT_W = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYC - 1);

    arb_state_t          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_owner;
    logic                r_we;
    logic                r_drive;
    logic [ADDR_W-1:0]   r_address;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_done;
    logic                r_wen;
    logic                r_ren;

    logic [ADDR_W-1:0]   w_addr  [NUM_REQ];
    logic [DATA_W-1:0]   w_wdata [NUM_REQ];
    logic [NUM_REQ-1:0]  w_winner;
    logic                w_valid;
    logic                w_win_idx;
    logic                w_ptr;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
        assign w_addr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
    end

    sram_arb_pick u_pick (
        .req    (bus.req),
        .ptr    (w_ptr),
        .winner (w_winner),
        .valid  (w_valid)
    );

    assign w_win_idx = onehot_to_idx(w_winner);

`ifdef SRAM_ARB_FIXED_PRI_EN
    assign w_ptr = 1'b0;
`else
    logic r_ptr;

    // After any grant the pointer favours the requester that did not win.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (r_state == IDLE && w_valid) begin
            r_ptr <= ~w_win_idx;
        end
    end

    assign w_ptr = r_ptr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_drive   <= 1'b0;
            r_address <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_wen     <= 1'b0;
            r_ren     <= 1'b0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_gnt     <= w_winner;
                        r_owner   <= w_win_idx;
                        r_we      <= bus.req_we[w_win_idx];
                        r_drive   <= bus.req_we[w_win_idx];
                        r_address <= w_addr[w_win_idx];
                        r_wdata   <= w_wdata[w_win_idx];
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    r_wen   <= r_we;
                    r_ren   <= ~r_we;
                    r_cnt   <= '0;
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (r_cnt == CNT_LAST) begin
                        // Read data is sampled while the read strobe is still high.
                        if (!r_we) begin
                            r_rdata <= sram_data;
                        end
                        r_wen   <= 1'b0;
                        r_ren   <= 1'b0;
                        r_drive <= 1'b0;
                        r_state <= RECOVER;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RECOVER: begin
                    r_done  <= r_owner ? 2'b10 : 2'b01;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sram_data         = r_drive ? r_wdata : {DATA_W{1'bz}};
    assign sram_address      = r_address;
    assign sram_write_enable = r_wen;
    assign sram_read_enable  = r_ren;

    assign bus.gnt   = r_gnt;
    assign bus.done  = r_done;
    assign bus.rdata = r_rdata;
    assign bus.busy  = (r_state != IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 8K x 8 SRAM.
// The data bus is pulled up, so an undriven bus reads as 8'hFF.
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst;
    logic [12:0] sram_address;
    logic        sram_write_enable;
    logic        sram_read_enable;
    wire  [7:0]  sram_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:8191];

    sram_port_arbiter_if #(.ADDR_W(13), .DATA_W(8)) bus ();

    sram_port_arbiter #(.ADDR_W(13), .DATA_W(8), .ACCESS_CYC(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .sram_address      (sram_address),
        .sram_write_enable (sram_write_enable),
        .sram_read_enable  (sram_read_enable),
        .sram_data         (sram_data)
    );

    for (genvar gi = 0; gi < 8; gi++) begin : g_pull
        pullup (sram_data[gi]);
    end

    assign sram_data = sram_read_enable ? mem[sram_address] : 8'bzzzzzzzz;

    always @(posedge clk) begin
        if (sram_write_enable) mem[sram_address] <= sram_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (sram_write_enable && sram_read_enable) begin
                failures++;
                $display("FAIL enables_exclusive: we=%0b re=%0b required not both 1", sram_write_enable, sram_read_enable);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one access from requester `who`; returns what was seen on the bus.
    task automatic do_access(input int who, input logic we, input logic [12:0] addr,
                             input logic [7:0] wd, output logic [1:0] g, output int lat,
                             output int wec, output int rec, output logic [7:0] sdat,
                             output logic [12:0] sadr, output logic [7:0] rd, output bit tmo);
        bit seen_done;
        tmo = 0; g = 2'b00; lat = 0; wec = 0; rec = 0; seen_done = 0;
        @(negedge clk);
        bus.req[who] = 1'b1;
        bus.req_we[who] = we;
        bus.req_addr[who*13 +: 13] = addr;
        bus.req_wdata[who*8 +: 8] = wd;
        for (int i = 0; i < 20 && g == 2'b00; i++) begin
            @(negedge clk);
            g = bus.gnt;
        end
        if (g == 2'b00) tmo = 1;
        sdat = sram_data;
        sadr = sram_address;
        bus.req[who] = 1'b0;
        for (int i = 0; i < 20 && !seen_done; i++) begin
            @(negedge clk);
            lat++;
            if (sram_write_enable) wec++;
            if (sram_read_enable) rec++;
            if (bus.done != 2'b00) seen_done = 1;
        end
        if (!seen_done) tmo = 1;
        rd = bus.rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.gnt !== 2'b00 || bus.done !== 2'b00 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: gnt=%b done=%b busy=%b required 00 00 0", bus.gnt, bus.done, bus.busy);
        end
        checks++;
        if (sram_write_enable !== 1'b0 || sram_read_enable !== 1'b0 || sram_address !== 13'h0) begin
            failures++;
            $display("FAIL reset_sram: we=%b re=%b addr=%h required 0 0 0000", sram_write_enable, sram_read_enable, sram_address);
        end
        checks++;
        if (bus.rdata !== 8'h00 || sram_data !== 8'hFF) begin
            failures++;
            $display("FAIL reset_data: rdata=%h bus=%h required 00 FF(released)", bus.rdata, sram_data);
        end
        rst = 1'b0;
        $display("reset: released");
    endtask

    task automatic test_write();
        logic [1:0] g; int lat, wec, rec; logic [7:0] sd, rd; logic [12:0] sa; bit tmo;
        do_access(0, 1'b1, 13'h0000, 8'hA5, g, lat, wec, rec, sd, sa, rd, tmo);
        $display("write0: gnt=%b lat=%0d we_cyc=%0d setup_data=%h", g, lat, wec, sd);
        checks++;
        if (tmo || g !== 2'b01 || lat != 4) begin
            failures++;
            $display("FAIL write0_handshake: tmo=%0b gnt=%b lat=%0d required 0 01 4", tmo, g, lat);
        end
        checks++;
        if (wec != 2 || rec != 0 || sd !== 8'hA5 || sa !== 13'h0000) begin
            failures++;
            $display("FAIL write0_bus: we_cyc=%0d re_cyc=%0d data=%h addr=%h required 2 0 A5 0000", wec, rec, sd, sa);
        end
        do_access(1, 1'b1, 13'h0001, 8'h5A, g, lat, wec, rec, sd, sa, rd, tmo);
        $display("write1: gnt=%b lat=%0d we_cyc=%0d setup_data=%h", g, lat, wec, sd);
        checks++;
        if (tmo || g !== 2'b10 || lat != 4) begin
            failures++;
            $display("FAIL write1_handshake: tmo=%0b gnt=%b lat=%0d required 0 10 4", tmo, g, lat);
        end
        checks++;
        if (wec != 2 || rec != 0 || sd !== 8'h5A || sa !== 13'h0001) begin
            failures++;
            $display("FAIL write1_bus: we_cyc=%0d re_cyc=%0d data=%h addr=%h required 2 0 5A 0001", wec, rec, sd, sa);
        end
    endtask

    task automatic test_read();
        logic [1:0] g; int lat, wec, rec; logic [7:0] sd, rd; logic [12:0] sa; bit tmo;
        do_access(0, 1'b0, 13'h0000, 8'h00, g, lat, wec, rec, sd, sa, rd, tmo);
        $display("read0: gnt=%b lat=%0d rdata=%h", g, lat, rd);
        checks++;
        if (tmo || g !== 2'b01 || lat != 4 || rd !== 8'hA5) begin
            failures++;
            $display("FAIL read0: tmo=%0b gnt=%b lat=%0d rdata=%h required 0 01 4 A5", tmo, g, lat, rd);
        end
        checks++;
        if (rec != 2 || wec != 0 || sd !== 8'hFF) begin
            failures++;
            $display("FAIL read0_bus: re_cyc=%0d we_cyc=%0d setup_bus=%h required 2 0 FF(released)", rec, wec, sd);
        end
        do_access(0, 1'b0, 13'h0001, 8'h00, g, lat, wec, rec, sd, sa, rd, tmo);
        $display("read1: gnt=%b lat=%0d rdata=%h", g, lat, rd);
        checks++;
        if (tmo || g !== 2'b01 || rd !== 8'h5A || sd !== 8'hFF) begin
            failures++;
            $display("FAIL read1: tmo=%0b gnt=%b rdata=%h setup_bus=%h required 0 01 5A FF", tmo, g, rd, sd);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rdata !== 8'h5A) begin
            failures++;
            $display("FAIL rdata_hold: rdata=%h required 5A", bus.rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] gv [4];
        int         gt [4];
        logic [1:0] dv [4];
        logic [7:0] dr [4];
        logic [1:0] exp_g;
        logic [7:0] exp_r;
        int ng = 0, nd = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req_we = 2'b00;
        bus.req_addr = {13'h0001, 13'h0000};
        bus.req = 2'b11;
        for (int cyc = 0; cyc < 60 && nd < 4; cyc++) begin
            @(negedge clk);
            if (bus.gnt != 2'b00 && ng < 4) begin
                gv[ng] = bus.gnt; gt[ng] = cyc; ng++;
                if (ng == 4) bus.req = 2'b00;
            end
            if (bus.done != 2'b00 && nd < 4) begin
                dv[nd] = bus.done; dr[nd] = bus.rdata; nd++;
            end
        end
        bus.req = 2'b00;
        checks++;
        if (ng != 4 || nd != 4) begin
            failures++;
            $display("FAIL b2b_count: grants=%0d dones=%0d required 4 4", ng, nd);
        end else begin
            for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_FIXED_PRI_EN
                exp_g = 2'b01;
`else
                exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
                exp_r = (exp_g == 2'b01) ? 8'hA5 : 8'h5A;
                $display("b2b[%0d]: gnt=%b cyc=%0d done=%b rdata=%h", k, gv[k], gt[k], dv[k], dr[k]);
                checks++;
                if (gv[k] !== exp_g || dv[k] !== exp_g || dr[k] !== exp_r) begin
                    failures++;
                    $display("FAIL b2b_grant%0d: gnt=%b done=%b rdata=%h required %b %b %h", k, gv[k], dv[k], dr[k], exp_g, exp_g, exp_r);
                end
                if (k > 0) begin
                    checks++;
                    if (gt[k] - gt[k-1] != 5) begin
                        failures++;
                        $display("FAIL b2b_spacing%0d: interval=%0d required 5", k, gt[k] - gt[k-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_top_address();
        logic [1:0] g; int lat, wec, rec; logic [7:0] sd, rd; logic [12:0] sa; bit tmo;
        do_access(0, 1'b1, 13'h1FFF, 8'hFF, g, lat, wec, rec, sd, sa, rd, tmo);
        $display("top_write: gnt=%b addr=%h", g, sa);
        checks++;
        if (tmo || sa !== 13'h1FFF || wec != 2) begin
            failures++;
            $display("FAIL top_write: tmo=%0b addr=%h we_cyc=%0d required 0 1FFF 2", tmo, sa, wec);
        end
        do_access(0, 1'b0, 13'h1FFF, 8'h00, g, lat, wec, rec, sd, sa, rd, tmo);
        $display("top_read: gnt=%b addr=%h rdata=%h", g, sa, rd);
        checks++;
        if (tmo || sa !== 13'h1FFF || rd !== 8'hFF || mem[0] !== 8'hA5) begin
            failures++;
            $display("FAIL top_read: tmo=%0b addr=%h rdata=%h mem0=%h required 0 1FFF FF A5", tmo, sa, rd, mem[0]);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [1:0] g = 2'b00;
        bit saw_done = 0;
        @(negedge clk);
        bus.req_we[0] = 1'b1;
        bus.req_addr[12:0] = 13'h0005;
        bus.req_wdata[7:0] = 8'h77;
        bus.req[0] = 1'b1;
        for (int i = 0; i < 20 && g == 2'b00; i++) begin
            @(negedge clk);
            g = bus.gnt;
        end
        bus.req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (g !== 2'b01 || sram_write_enable !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: gnt=%b we=%b required 01 1", g, sram_write_enable);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("midrst: we=%b re=%b bus=%h busy=%b rdata=%h", sram_write_enable, sram_read_enable, sram_data, bus.busy, bus.rdata);
        checks++;
        if (sram_write_enable !== 1'b0 || sram_read_enable !== 1'b0 || sram_data !== 8'hFF) begin
            failures++;
            $display("FAIL midrst_sram: we=%b re=%b bus=%h required 0 0 FF(released)", sram_write_enable, sram_read_enable, sram_data);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.rdata !== 8'h00 || bus.done !== 2'b00) begin
            failures++;
            $display("FAIL midrst_state: busy=%b rdata=%h done=%b required 0 00 00", bus.busy, bus.rdata, bus.done);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done != 2'b00) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL midrst_no_done: done pulse seen, required none");
        end
        // Pointer must be back at requester 0 after reset.
        bus.req_we = 2'b00;
        bus.req = 2'b11;
        g = 2'b00;
        for (int i = 0; i < 20 && g == 2'b00; i++) begin
            @(negedge clk);
            g = bus.gnt;
        end
        bus.req = 2'b00;
        $display("midrst_ptr: gnt=%b", g);
        checks++;
        if (g !== 2'b01) begin
            failures++;
            $display("FAIL midrst_ptr: gnt=%b required 01", g);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (sram_data !== 8'hFF || bus.busy !== 1'b0 || bus.gnt !== 2'b00) begin
                failures++;
                $display("FAIL idle%0d: bus=%h busy=%b gnt=%b required FF 0 00", i, sram_data, bus.busy, bus.gnt);
            end
        end
        $display("idle: 10 cycles observed");
    endtask

    initial begin
        rst           = 1'b1;
        bus.req       = 2'b00;
        bus.req_we    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_top_address();
        test_reset_mid_access();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
